// File: rtl/core.sv
`default_nettype none
// ============================================================================
// Module   : core
// Brief    : Single-cycle MIPS-subset processor (add/sub/and/or/slt, lw, sw,
//            beq, addi, j) with a 32-entry register file.
// Revision : 1.0 - initial release
// ============================================================================
module core #(
    parameter int DATA_WIDTH_P      = 32,
    parameter int DATA_ADDR_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P      = 5,
    parameter int CNTRL_WIDTH_P     = 3,
    parameter int ALU_CNTRL_WIDTH_P = 3,
    parameter int FUNCT_WIDTH_P     = 6,
    parameter int OP_WIDTH_P        = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH_P-1:0]      i_instr,
    output logic [DATA_WIDTH_P-1:0]      o_pc,
    input  logic [DATA_WIDTH_P-1:0]      i_mem_rd_data,
    output logic                         o_mem_wr_en,
    output logic [DATA_ADDR_WIDTH_P-1:0] o_mem_wr_addr,
    output logic [DATA_WIDTH_P-1:0]      o_mem_wr_data
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH_P;

    localparam logic [OP_WIDTH_P-1:0] c_OP_RTYPE = 6'b000000;
    localparam logic [OP_WIDTH_P-1:0] c_OP_LW    = 6'b100011;
    localparam logic [OP_WIDTH_P-1:0] c_OP_SW    = 6'b101011;
    localparam logic [OP_WIDTH_P-1:0] c_OP_BEQ   = 6'b000100;
    localparam logic [OP_WIDTH_P-1:0] c_OP_ADDI  = 6'b001000;
    localparam logic [OP_WIDTH_P-1:0] c_OP_J     = 6'b000010;

    localparam logic [FUNCT_WIDTH_P-1:0] c_FN_ADD = 6'b100000;
    localparam logic [FUNCT_WIDTH_P-1:0] c_FN_SUB = 6'b100010;
    localparam logic [FUNCT_WIDTH_P-1:0] c_FN_AND = 6'b100100;
    localparam logic [FUNCT_WIDTH_P-1:0] c_FN_OR  = 6'b100101;
    localparam logic [FUNCT_WIDTH_P-1:0] c_FN_SLT = 6'b101010;

    localparam logic [CNTRL_WIDTH_P-1:0] c_ALUOP_ADD   = 3'b000;
    localparam logic [CNTRL_WIDTH_P-1:0] c_ALUOP_SUB   = 3'b001;
    localparam logic [CNTRL_WIDTH_P-1:0] c_ALUOP_FUNCT = 3'b010;

    localparam logic [ALU_CNTRL_WIDTH_P-1:0] c_ALU_ADD = 3'b010;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] c_ALU_SUB = 3'b110;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] c_ALU_AND = 3'b000;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] c_ALU_OR  = 3'b001;
    localparam logic [ALU_CNTRL_WIDTH_P-1:0] c_ALU_SLT = 3'b111;

    logic [DATA_WIDTH_P-1:0] pc_q;
    logic [DATA_WIDTH_P-1:0] pc_d;
    logic [DATA_WIDTH_P-1:0] regs_q [c_NUM_REGS];

    logic [OP_WIDTH_P-1:0]    w_op;
    logic [FUNCT_WIDTH_P-1:0] w_funct;
    logic [ADDR_WIDTH_P-1:0]  w_rs;
    logic [ADDR_WIDTH_P-1:0]  w_rt;
    logic [ADDR_WIDTH_P-1:0]  w_rd;
    logic [DATA_WIDTH_P-1:0]  w_imm_ext;

    assign w_op      = i_instr[31:26];
    assign w_rs      = i_instr[25:21];
    assign w_rt      = i_instr[20:16];
    assign w_rd      = i_instr[15:11];
    assign w_funct   = i_instr[FUNCT_WIDTH_P-1:0];
    assign w_imm_ext = {{(DATA_WIDTH_P-16){i_instr[15]}}, i_instr[15:0]};

    logic                     w_reg_write;
    logic                     w_reg_dst;
    logic                     w_alu_src;
    logic                     w_branch;
    logic                     w_mem_write;
    logic                     w_mem_to_reg;
    logic                     w_jump;
    logic [CNTRL_WIDTH_P-1:0] w_alu_op;
    logic                     w_funct_ok;

    always_comb begin
        w_funct_ok = 1'b0;
        case (w_funct)
            c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: w_funct_ok = 1'b1;
            default:                                         w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_jump       = 1'b0;
        w_alu_op     = c_ALUOP_ADD;
        case (w_op)
            c_OP_RTYPE: begin
                w_reg_write = w_funct_ok;
                w_reg_dst   = 1'b1;
                w_alu_op    = c_ALUOP_FUNCT;
            end
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            c_OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OP_BEQ: begin
                w_branch = 1'b1;
                w_alu_op = c_ALUOP_SUB;
            end
            c_OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_J: w_jump = 1'b1;
            default: ;
        endcase
    end

    logic [ALU_CNTRL_WIDTH_P-1:0] w_alu_ctl;

    always_comb begin
        w_alu_ctl = c_ALU_ADD;
        case (w_alu_op)
            c_ALUOP_SUB: w_alu_ctl = c_ALU_SUB;
            c_ALUOP_FUNCT: begin
                case (w_funct)
                    c_FN_SUB: w_alu_ctl = c_ALU_SUB;
                    c_FN_AND: w_alu_ctl = c_ALU_AND;
                    c_FN_OR:  w_alu_ctl = c_ALU_OR;
                    c_FN_SLT: w_alu_ctl = c_ALU_SLT;
                    default:  w_alu_ctl = c_ALU_ADD;
                endcase
            end
            default: w_alu_ctl = c_ALU_ADD;
        endcase
    end

    logic [DATA_WIDTH_P-1:0] w_rs_val;
    logic [DATA_WIDTH_P-1:0] w_rt_val;
    logic [DATA_WIDTH_P-1:0] w_alu_b;
    logic [DATA_WIDTH_P-1:0] w_alu_res;

    // Register 0 is hard-wired to zero on the read side as well.
    assign w_rs_val = (w_rs == '0) ? '0 : regs_q[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 : regs_q[w_rt];
    assign w_alu_b  = w_alu_src ? w_imm_ext : w_rt_val;

    always_comb begin
        w_alu_res = w_rs_val + w_alu_b;
        case (w_alu_ctl)
            c_ALU_SUB: w_alu_res = w_rs_val - w_alu_b;
            c_ALU_AND: w_alu_res = w_rs_val & w_alu_b;
            c_ALU_OR:  w_alu_res = w_rs_val | w_alu_b;
            c_ALU_SLT: w_alu_res = {{(DATA_WIDTH_P-1){1'b0}},
                                    ($signed(w_rs_val) < $signed(w_alu_b))};
            default:   w_alu_res = w_rs_val + w_alu_b;
        endcase
    end

    logic [DATA_WIDTH_P-1:0] w_pc_plus4;
    logic [DATA_WIDTH_P-1:0] w_br_target;
    logic [DATA_WIDTH_P-1:0] w_j_target;
    logic                    w_take_br;

    assign w_pc_plus4  = pc_q + 'd4;
    assign w_br_target = w_pc_plus4 + (w_imm_ext << 2);
    assign w_j_target  = {w_pc_plus4[DATA_WIDTH_P-1:28], i_instr[25:0], 2'b00};
    assign w_take_br   = w_branch && (w_alu_res == '0);

    always_comb begin
        pc_d = w_pc_plus4;
        if (w_jump) begin
            pc_d = w_j_target;
        end else if (w_take_br) begin
            pc_d = w_br_target;
        end
    end

    logic [ADDR_WIDTH_P-1:0] w_waddr;
    logic [DATA_WIDTH_P-1:0] w_wdata;

    assign w_waddr = w_reg_dst ? w_rd : w_rt;
    assign w_wdata = w_mem_to_reg ? i_mem_rd_data : w_alu_res;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= '0;
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (w_reg_write && (w_waddr != '0)) begin
                regs_q[w_waddr] <= w_wdata;
            end
        end
    end

    assign o_pc          = pc_q;
    assign o_mem_wr_en   = w_mem_write & reset;
    assign o_mem_wr_addr = w_alu_res[DATA_ADDR_WIDTH_P-1:0];
    assign o_mem_wr_data = w_rt_val;

endmodule
`default_nettype wire

// File: tb/tb_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_core
// Brief    : Self-checking bench for core: directed program plus random
//            instruction stream against an architectural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] r_instr;
    logic [31:0] r_rd_data;
    logic [31:0] w_pc;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    core dut (
        .clk           (clk),
        .reset         (reset),
        .i_instr       (r_instr),
        .o_pc          (w_pc),
        .i_mem_rd_data (r_rd_data),
        .o_mem_wr_en   (w_we),
        .o_mem_wr_addr (w_addr),
        .o_mem_wr_data (w_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    bit          m_pc_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] i_fmt(input int op, input int rs, input int rt, input int imm);
        logic [31:0] v;
        v = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] r_fmt(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] v;
        v = {6'b0, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn[5:0]};
        return v;
    endfunction

    function automatic void m_write(input logic [4:0] idx, input logic [31:0] val);
        if (idx != 5'd0) m_regs[idx] = val;
    endfunction

    // Drive one instruction for one cycle; check outputs, then advance the model.
    task automatic step(input logic [31:0] ins, input logic [31:0] rdat, input logic rst_n);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, simm, nxt;
        r_instr   = ins;
        r_rd_data = rdat;
        reset     = rst_n;
        #1;
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        fn   = ins[5:0];
        a    = m_regs[rs];
        b    = m_regs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        if (m_pc_known) check("pc", w_pc, m_pc);
        check("wr_en", {31'b0, w_we}, {31'b0, rst_n && op == 6'b101011});
        if (rst_n && op == 6'b101011) begin
            check("sw_addr", w_addr, a + simm);
            check("sw_data", w_wdata, b);
        end
        if (rst_n && op == 6'b100011) check("lw_addr", w_addr, a + simm);
        if (!rst_n) begin
            m_pc       = 32'd0;
            m_pc_known = 1'b1;
            foreach (m_regs[i]) m_regs[i] = 32'd0;
        end else begin
            nxt = m_pc + 32'd4;
            case (op)
                6'b000000: case (fn)
                    6'b100000: m_write(rd, a + b);
                    6'b100010: m_write(rd, a - b);
                    6'b100100: m_write(rd, a & b);
                    6'b100101: m_write(rd, a | b);
                    6'b101010: m_write(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    default: ;
                endcase
                6'b100011: m_write(rt, rdat);
                6'b001000: m_write(rt, a + simm);
                6'b000100: if (a == b) nxt = m_pc + 32'd4 + (simm << 2);
                6'b000010: nxt = {nxt[31:28], ins[25:0], 2'b00};
                default: ;
            endcase
            m_pc = nxt;
        end
        @(negedge clk);
    endtask

    // Explicit hand-computed store check before the cycle is stepped.
    task automatic expect_sw(input string tag, input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] data);
        r_instr = ins;
        reset   = 1'b1;
        #1;
        check({tag, "_addr"}, w_addr, addr);
        check({tag, "_data"}, w_wdata, data);
        step(ins, 32'd0, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        k = $urandom_range(0, 15);
        case (k)
            0, 1, 2:    return i_fmt(6'b001000, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            3, 4, 5, 6: begin
                int sel;
                logic [5:0] fns [5];
                fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
                sel = $urandom_range(0, 4);
                return r_fmt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fns[sel]);
            end
            7, 8:       return i_fmt(6'b101011, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            9:          return i_fmt(6'b100011, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            10, 11:     return i_fmt(6'b000100, $urandom_range(0, 7), $urandom_range(0, 7),
                                     $urandom_range(0, 16) - 8);
            12: begin
                logic [31:0] t;
                t = $urandom;
                return {6'b000010, t[25:0]};
            end
            13:         return r_fmt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                     $urandom_range(0, 63));
            default:    return $urandom;
        endcase
    endfunction

    initial begin
        foreach (m_regs[i]) m_regs[i] = 32'd0;
        r_instr   = 32'd0;
        r_rd_data = 32'd0;
        reset     = 1'b0;

        step(32'd0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 1'b0);
        check("rst_pc", w_pc, 32'h0);
        step(32'd0, 32'd0, 1'b1);
        check("nop_pc4", w_pc, 32'h4);
        step(32'd0, 32'd0, 1'b1);
        check("nop_pc8", w_pc, 32'h8);

        // A store presented during reset must not strobe memory.
        step(i_fmt(6'b101011, 0, 4, 84), 32'd0, 1'b0);
        step(i_fmt(6'b001000, 0, 2, 5), 32'd0, 1'b1);
        step(i_fmt(6'b001000, 0, 3, 12), 32'd0, 1'b1);
        step(r_fmt(2, 3, 4, 6'b100000), 32'd0, 1'b1);
        step(r_fmt(3, 2, 5, 6'b100010), 32'd0, 1'b1);
        check("pre_beq_pc", w_pc, 32'h10);
        step(i_fmt(6'b000100, 2, 2, 2), 32'd0, 1'b1);
        check("beq_taken", w_pc, 32'h1C);
        step(r_fmt(2, 3, 6, 6'b101010), 32'd0, 1'b1);
        check("pre_j_pc", w_pc, 32'h20);
        step({6'b000010, 26'h11}, 32'd0, 1'b1);
        check("j_pc", w_pc, 32'h44);
        expect_sw("sw4", i_fmt(6'b101011, 0, 4, 84), 32'd84, 32'd17);
        step(i_fmt(6'b100011, 0, 7, 84), 32'd17, 1'b1);
        expect_sw("sw7", i_fmt(6'b101011, 0, 7, 84), 32'd84, 32'd17);
        step(i_fmt(6'b000100, 2, 3, 2), 32'd0, 1'b1);
        check("beq_not", w_pc, 32'h54);
        expect_sw("sw5", i_fmt(6'b101011, 0, 5, 0), 32'd0, 32'd7);
        expect_sw("sw6", i_fmt(6'b101011, 0, 6, 4), 32'd4, 32'd1);
        step(i_fmt(6'b001000, 0, 0, 9), 32'd0, 1'b1);
        step(r_fmt(0, 0, 8, 6'b100000), 32'd0, 1'b1);
        expect_sw("sw8", i_fmt(6'b101011, 0, 8, 8), 32'd8, 32'd0);
        step(32'hFC00_0000, 32'd0, 1'b1);
        check("undef_pc", w_pc, 32'h6C);
        step(r_fmt(3, 3, 2, 6'b111111), 32'd0, 1'b1);
        expect_sw("sw2", i_fmt(6'b101011, 0, 2, 0), 32'd0, 32'd5);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 63) == 0) step(rand_instr(), $urandom, 1'b0);
            else                            step(rand_instr(), $urandom, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH_P, 32, datapath/instruction/PC width; DATA_ADDR_WIDTH_P, 32, data-memory address width; ADDR_WIDTH_P, 5, register-file index width; CNTRL_WIDTH_P, 3, main-decoder ALU-op width; ALU_CNTRL_WIDTH_P, 3, ALU control width; FUNCT_WIDTH_P, 6, funct field width; OP_WIDTH_P, 6, opcode width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 i_instr  input  DATA_WIDTH_P  instruction fetched at address o_pc (combinational instruction memory).
REQ-005 o_pc  output  DATA_WIDTH_P  current program counter (byte address).
REQ-006 i_mem_rd_data  input  DATA_WIDTH_P  data-memory read data for address o_mem_wr_addr (combinational).
REQ-007 o_mem_wr_en  output  1  data-memory write strobe, sampled by memory on rising clk.
REQ-008 o_mem_wr_addr  output  DATA_ADDR_WIDTH_P  data-memory address (ALU result); used for both loads and stores.
REQ-009 o_mem_wr_data  output  DATA_WIDTH_P  store data (register rt value).

Function
REQ-010 Single-cycle MIPS-subset core: each instruction completes in one clk cycle; PC, register file update on the rising edge ending that cycle.
REQ-011 Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0] sign-extended to 32 bits, jump target=[25:0].
REQ-012 Register file: 32 x DATA_WIDTH_P, two combinational read ports, one write port; register 0 always reads 0, writes to it ignored.
REQ-013 R-type (op 000000): funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0); rd <= result.
REQ-014 lw (100011): address = rs + imm; rt <= i_mem_rd_data.
REQ-015 sw (101011): address = rs + imm; o_mem_wr_en=1, o_mem_wr_data=rt; no register write.
REQ-016 beq (000100): if rs == rt, PC <= PC+4 + (imm << 2); else PC+4.
REQ-017 addi (001000): rt <= rs + imm.
REQ-018 j (000010): PC <= {PC+4[31:28], target, 2'b00}.
REQ-019 All other PC updates: PC <= PC + 4; arithmetic is modulo 2^32, no overflow traps.
REQ-020 ALU control codes: 010 add, 110 sub, 000 and, 001 or, 111 slt; decoder ALU-op 000 add, 001 sub, 010 use funct.
REQ-021 Unrecognised opcode or funct: no register write, o_mem_wr_en=0, PC+4.
REQ-022 o_mem_wr_en is 1 only during sw; o_mem_wr_addr/o_mem_wr_data may carry ALU/rt values on other cycles.

Reset
REQ-023 On rising clk with reset=0: PC <= 0, all 32 registers <= 0.
REQ-024 While reset=0, o_mem_wr_en SHALL be forced 0 and no register write occurs.
REQ-025 First instruction after reset=1 is fetched from address 0; reset asserted mid-program takes effect at next rising edge regardless of current instruction.

Verification
REQ-026 Hold reset=0 two cycles, release -> o_pc=0, then 4, 8 on successive edges with NOP (0x00000000) instructions.
REQ-027 addi $2,$0,5; addi $3,$0,12; add $4,$2,$3; sub $5,$3,$2 -> $4=17, $5=7; slt $6,$2,$3 -> 1.
REQ-028 sw $4,84($0) with $4=17 -> o_mem_wr_en=1, o_mem_wr_addr=84, o_mem_wr_data=17 that cycle; lw $7,84($0) with i_mem_rd_data=17 -> $7=17, o_mem_wr_en=0.
REQ-029 beq $2,$2,+2 at PC=0x10 -> next PC=0x1C; beq with unequal regs -> 0x14; j 0x11 at PC=0x20 -> PC=0x44.
REQ-030 addi $0,$0,9 then add $8,$0,$0 -> $8=0; undefined opcode 0xFC000000 -> no writes, PC+4.
